autoconfig_zii_multi: RTL and testbench

- Clocked, parametrised Zorro II AutoConfig engine presenting NUM_BOARDS logical boards in sequence (e.g. RAM, IDE, flash ROM) through one CFGIN_n/CFGOUT_n slot.
- Replaces per-board hand-coded async logic with a synchronised bus-cycle FSM, per-board parameter tables, runtime alternate-size selection, and a packed base-address output bus.
- Sits between the CPU bus (A, D, AS_n, DS_n, RW_n) and the board decoders that consume BASE/CONFIGURED_n.

---
 rtl/autoconfig_zii_multi.sv | 195 +++++++++++++++++++
 tb/tb_autoconfig_zii_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/autoconfig_zii_multi.sv
// Zorro II AutoConfig engine presenting NUM_BOARDS logical boards in turn
// through a single CFGIN_n/CFGOUT_n slot. Bus strobes are synchronised into
// CLK; every configuration register read/write is decoded by a small FSM.
module autoconfig_zii_multi #(
   parameter int                         NUM_BOARDS  = 2,
   parameter logic [15:0]                MFG_ID      = 16'h082C,
   parameter logic [31:0]                SERIAL      = 32'h0,
   parameter logic [8*NUM_BOARDS-1:0]    ER_TYPE     = {8'hD1, 8'hE0},
   parameter logic [8*NUM_BOARDS-1:0]    ER_TYPE_ALT = {8'hD1, 8'hE7},
   parameter logic [8*NUM_BOARDS-1:0]    PROD_ID     = {8'd6, 8'd8},
   parameter logic [8*NUM_BOARDS-1:0]    ER_FLAGS    = {8'hC0, 8'hC0},
   parameter logic [16*NUM_BOARDS-1:0]   ROM_VEC     = {16'h0001, 16'h0000}
) (
   input  logic                      CLK,
   input  logic                      RESET_n,
   input  logic                      CFGIN_n,
   input  logic                      AS_n,
   input  logic                      DS_n,
   input  logic                      RW_n,
   input  logic [23:1]               A,
   input  logic [NUM_BOARDS-1:0]     ALT_SEL,
   input  logic [3:0]                D_IN,
   output logic [3:0]                D_OUT,
   output logic                      D_OE,
   output logic [8*NUM_BOARDS-1:0]   BASE,
   output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
   output logic                      CFGOUT_n
);

   // idx runs 0..NUM_BOARDS; the value NUM_BOARDS means "all boards done".
   localparam int            IW = $clog2(NUM_BOARDS + 1);
   localparam logic [IW-1:0] NB = IW'(NUM_BOARDS);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_WAIT_AS} state_t;

   state_t                    state_q;
   logic                      as_meta_q, as_sync_q;
   logic                      ds_meta_q, ds_sync_q, ds_prev_q;
   logic [IW-1:0]             idx_q, idx_d;
   logic [3:0]                staging_q;
   logic [3:0]                d_out_q;
   logic                      oe_q;
   logic                      cfgout_n_q;
   logic [8*NUM_BOARDS-1:0]   base_q;
   logic [NUM_BOARDS-1:0]     configured_n_q;
   logic [NUM_BOARDS-1:0]     shutup_q;

   logic                      ds_fall;
   logic                      sel;
   logic [7:0]                cur_type, cur_prod, cur_flags;
   logic [15:0]               cur_rom;
   logic                      cur_done;
   logic [3:0]                rd_nib;
   logic [15:0]               mfg_sh, rom_sh;
   logic [31:0]               ser_sh;
   logic [2:0]                ser_nib;
   logic                      unused_addr;

   // Middle address bits play no part in the AutoConfig decode.
   assign unused_addr = ^A[15:7];

   assign ds_fall = ds_prev_q & ~ds_sync_q;
   assign sel     = ~CFGIN_n & (idx_q < NB) & (A[23:16] == 8'hE8);

   // Two-flop synchronisers for the asynchronous strobes, plus a DS_n history flop for edge detect.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         as_meta_q <= 1'b1;
         as_sync_q <= 1'b1;
         ds_meta_q <= 1'b1;
         ds_sync_q <= 1'b1;
         ds_prev_q <= 1'b1;
      end else begin
         as_meta_q <= AS_n;
         as_sync_q <= as_meta_q;
         ds_meta_q <= DS_n;
         ds_sync_q <= ds_meta_q;
         ds_prev_q <= ds_sync_q;
      end
   end

   // Pick the parameter set and done flag of the board currently being configured.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      cur_type  = 8'h00;
      cur_prod  = 8'h00;
      cur_flags = 8'h00;
      cur_rom   = 16'h0000;
      cur_done  = 1'b0;
      for (int i = 0; i < NUM_BOARDS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_type  = ALT_SEL[i] ? ER_TYPE_ALT[8*i +: 8] : ER_TYPE[8*i +: 8];
            cur_prod  = PROD_ID[8*i +: 8];
            cur_flags = ER_FLAGS[8*i +: 8];
            cur_rom   = ROM_VEC[16*i +: 16];
            cur_done  = ~configured_n_q[i] | shutup_q[i];
         end
      end
   end

   // Read nibble mux: register 00/02 is true polarity, the rest are stored inverted on the bus.
   always_comb begin
      ser_nib = A[3:1] + 3'd4;
      mfg_sh  = MFG_ID << {A[2:1], 2'b00};
      rom_sh  = cur_rom << {A[2:1], 2'b00};
      ser_sh  = SERIAL << {ser_nib, 2'b00};
      rd_nib  = 4'hF;
      case (A[6:1]) inside
         6'h00:         rd_nib = cur_type[7:4];
         6'h01:         rd_nib = cur_type[3:0];
         6'h02:         rd_nib = ~cur_prod[7:4];
         6'h03:         rd_nib = ~cur_prod[3:0];
         6'h04:         rd_nib = ~cur_flags[7:4];
         6'h05:         rd_nib = ~cur_flags[3:0];
         [6'h08:6'h0B]: rd_nib = ~mfg_sh[15:12];
         [6'h0C:6'h13]: rd_nib = ~ser_sh[31:28];
         [6'h14:6'h17]: rd_nib = cur_type[4] ? ~rom_sh[15:12] : 4'hF;
         6'h20, 6'h21:  rd_nib = 4'h0;
         default:       rd_nib = 4'hF;
      endcase
   end

   // Advance to the next board when a bus cycle ends on a board that is configured or shut up.
   always_comb begin
      idx_d = idx_q;
      if ((state_q == ST_WAIT_AS) && as_sync_q && cur_done && (idx_q < NB)) begin
         idx_d = idx_q + IW'(1);
      end
   end

   // Bus-cycle FSM with registered read data, drive enable and configuration registers.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         staging_q      <= 4'h0;
         d_out_q        <= 4'hF;
         oe_q           <= 1'b0;
         cfgout_n_q     <= 1'b1;
         base_q         <= '0;
         configured_n_q <= '1;
         shutup_q       <= '0;
      end else begin
         idx_q      <= idx_d;
         cfgout_n_q <= (idx_d != NB);
         case (state_q)
            ST_IDLE: begin
               if (ds_fall && sel) begin
                  if (RW_n) begin
                     state_q <= ST_RD;
                     d_out_q <= rd_nib;
                     oe_q    <= 1'b1;
                  end else begin
                     state_q <= ST_WR;
                     case (A[6:1])
                        6'h25: staging_q <= D_IN;
                        6'h24: begin
                           for (int i = 0; i < NUM_BOARDS; i++) begin
                              if (idx_q == IW'(i)) begin
                                 base_q[8*i +: 8]  <= {D_IN, staging_q};
                                 configured_n_q[i] <= 1'b0;
                              end
                           end
                        end
                        6'h26: begin
                           for (int i = 0; i < NUM_BOARDS; i++) begin
                              if (idx_q == IW'(i)) shutup_q[i] <= 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ST_RD, ST_WR: state_q <= ST_WAIT_AS;
            ST_WAIT_AS: begin
               if (as_sync_q) begin
                  state_q <= ST_IDLE;
                  oe_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Drive enable is released asynchronously by the raw data strobe.
   assign D_OE         = oe_q & ~DS_n;
   assign D_OUT        = d_out_q;
   assign BASE         = base_q;
   assign CONFIGURED_n = configured_n_q;
   assign CFGOUT_n     = cfgout_n_q;

endmodule

// File: tb/tb_autoconfig_zii_multi.sv
// Directed bench for autoconfig_zii_multi with two boards and default parameters.
module tb_autoconfig_zii_multi;

   logic        CLK = 1'b0;
   logic        RESET_n;
   logic        CFGIN_n;
   logic        AS_n;
   logic        DS_n;
   logic        RW_n;
   logic [23:1] A;
   logic [1:0]  ALT_SEL;
   logic [3:0]  D_IN;
   logic [3:0]  D_OUT;
   logic        D_OE;
   logic [15:0] BASE;
   logic [1:0]  CONFIGURED_n;
   logic        CFGOUT_n;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   autoconfig_zii_multi dut (
      .CLK          (CLK),
      .RESET_n      (RESET_n),
      .CFGIN_n      (CFGIN_n),
      .AS_n         (AS_n),
      .DS_n         (DS_n),
      .RW_n         (RW_n),
      .A            (A),
      .ALT_SEL      (ALT_SEL),
      .D_IN         (D_IN),
      .D_OUT        (D_OUT),
      .D_OE         (D_OE),
      .BASE         (BASE),
      .CONFIGURED_n (CONFIGURED_n),
      .CFGOUT_n     (CFGOUT_n)
   );

   typedef struct {
      logic        cfgin_n;
      logic        alt0;
      logic [23:0] addr;
      logic        exp_oe;
      logic [3:0]  exp_dout;
   } rd_vec_t;

   rd_vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One 68000-style bus cycle; returns D_OE before/at/after the expected drive window.
   task automatic bus_cycle(input logic [23:0] addr, input logic rd, input logic [3:0] din,
                            output logic oe_early, output logic oe_on,
                            output logic [3:0] dout, output logic oe_off);
      @(negedge CLK);
      A    = addr[23:1];
      RW_n = rd;
      AS_n = 1'b0;
      @(negedge CLK);
      DS_n = 1'b0;
      D_IN = din;
      repeat (2) @(posedge CLK);
      #1 oe_early = D_OE;
      @(posedge CLK);
      #1 oe_on = D_OE;
      dout = D_OUT;
      repeat (2) @(negedge CLK);
      DS_n = 1'b1;
      AS_n = 1'b1;
      #1 oe_off = D_OE;
      repeat (5) @(posedge CLK);
      #1;
   endtask

   task automatic do_read(input string name, input logic [23:0] addr,
                          input logic exp_oe, input logic [3:0] exp_dout);
      logic e, o, f;
      logic [3:0] d;
      bus_cycle(addr, 1'b1, 4'h0, e, o, d, f);
      check({name, " oe_early"}, e, 1'b0);
      check({name, " oe"}, o, exp_oe);
      if (exp_oe) check({name, " dout"}, d, exp_dout);
      check({name, " oe_release"}, f, 1'b0);
   endtask

   task automatic do_write(input string name, input logic [23:0] addr, input logic [3:0] data);
      logic e, o, f;
      logic [3:0] d;
      bus_cycle(addr, 1'b0, data, e, o, d, f);
      check({name, " no_drive"}, {e, o, f}, 3'b000);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 24'hE80000, 1'b1, 4'hE};
      vecs[1]  = '{1'b0, 1'b0, 24'hE80002, 1'b1, 4'h0};
      vecs[2]  = '{1'b0, 1'b0, 24'hE80004, 1'b1, 4'hF};
      vecs[3]  = '{1'b0, 1'b0, 24'hE80006, 1'b1, 4'h7};
      vecs[4]  = '{1'b0, 1'b1, 24'hE80002, 1'b1, 4'h7};
      vecs[5]  = '{1'b0, 1'b0, 24'hE80040, 1'b1, 4'h0};
      vecs[6]  = '{1'b0, 1'b0, 24'hE80042, 1'b1, 4'h0};
      vecs[7]  = '{1'b0, 1'b0, 24'hE80010, 1'b1, 4'hF};
      vecs[8]  = '{1'b0, 1'b0, 24'hE80012, 1'b1, 4'h7};
      vecs[9]  = '{1'b0, 1'b0, 24'hE80014, 1'b1, 4'hD};
      vecs[10] = '{1'b0, 1'b0, 24'hE80016, 1'b1, 4'h3};
      vecs[11] = '{1'b0, 1'b0, 24'hE80008, 1'b1, 4'h3};
      vecs[12] = '{1'b0, 1'b0, 24'hE8000A, 1'b1, 4'hF};
      vecs[13] = '{1'b0, 1'b0, 24'hE80018, 1'b1, 4'hF};
      vecs[14] = '{1'b0, 1'b0, 24'hE8002E, 1'b1, 4'hF};
      vecs[15] = '{1'b0, 1'b0, 24'hE80030, 1'b1, 4'hF};
      vecs[16] = '{1'b1, 1'b0, 24'hE80000, 1'b0, 4'h0};
      vecs[17] = '{1'b0, 1'b0, 24'hE90000, 1'b0, 4'h0};

      RESET_n = 1'b0;
      CFGIN_n = 1'b0;
      AS_n    = 1'b1;
      DS_n    = 1'b1;
      RW_n    = 1'b1;
      A       = '0;
      ALT_SEL = 2'b00;
      D_IN    = 4'h0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst D_OUT", D_OUT, 4'hF);
      check("rst D_OE", D_OE, 1'b0);
      check("rst BASE", BASE, 16'h0000);
      check("rst CONFIGURED_n", CONFIGURED_n, 2'b11);
      check("rst CFGOUT_n", CFGOUT_n, 1'b1);
      @(negedge CLK);
      RESET_n = 1'b1;

      // Register reads on board 0, plus cycles that must not be answered.
      for (int i = 0; i < 18; i++) begin
         CFGIN_n = vecs[i].cfgin_n;
         ALT_SEL = {1'b0, vecs[i].alt0};
         do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_oe, vecs[i].exp_dout);
      end
      CFGIN_n = 1'b0;
      ALT_SEL = 2'b00;

      // Writes with CFGIN_n high are ignored.
      CFGIN_n = 1'b1;
      do_write("nocfg wr48", 24'hE80048, 4'h5);
      check("nocfg BASE", BASE, 16'h0000);
      check("nocfg CONFIGURED_n", CONFIGURED_n, 2'b11);
      CFGIN_n = 1'b0;

      // Configure board 0 at 0x24, then board 1 becomes visible.
      do_write("b0 wr4A", 24'hE8004A, 4'h4);
      check("b0 after 4A CONFIGURED_n", CONFIGURED_n, 2'b11);
      do_write("b0 wr48", 24'hE80048, 4'h2);
      check("b0 BASE", BASE, 16'h0024);
      check("b0 CONFIGURED_n", CONFIGURED_n, 2'b10);
      check("b0 CFGOUT_n", CFGOUT_n, 1'b1);
      do_read("b1 rd00", 24'hE80000, 1'b1, 4'hD);
      do_read("b1 rd2E", 24'hE8002E, 1'b1, 4'hE);

      // Shut up board 1: chain passes on, board stays unconfigured.
      do_write("b1 wr4C", 24'hE8004C, 4'h0);
      check("b1 CONFIGURED_n", CONFIGURED_n, 2'b10);
      check("b1 BASE", BASE, 16'h0024);
      check("done CFGOUT_n", CFGOUT_n, 1'b0);
      do_read("done rd00", 24'hE80000, 1'b0, 4'h0);
      do_write("done wr48", 24'hE80048, 4'h9);
      check("done BASE", BASE, 16'h0024);

      // Reset during an active read drops everything asynchronously.
      @(negedge CLK);
      A    = 23'(24'hE80000 >> 1);
      RW_n = 1'b1;
      AS_n = 1'b0;
      @(negedge CLK);
      RESET_n = 1'b1;
      @(negedge CLK);
      RESET_n = 1'b0;
      #2 RESET_n = 1'b1;
      @(negedge CLK);
      AS_n = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      check("restart CFGOUT_n", CFGOUT_n, 1'b1);
      @(negedge CLK);
      AS_n = 1'b0;
      @(negedge CLK);
      DS_n = 1'b0;
      repeat (4) @(posedge CLK);
      #1 check("midrd D_OE before", D_OE, 1'b1);
      #2 RESET_n = 1'b0;
      #1;
      check("midrd D_OE", D_OE, 1'b0);
      check("midrd D_OUT", D_OUT, 4'hF);
      check("midrd CONFIGURED_n", CONFIGURED_n, 2'b11);
      check("midrd BASE", BASE, 16'h0000);
      check("midrd CFGOUT_n", CFGOUT_n, 1'b1);
      @(negedge CLK);
      DS_n = 1'b1;
      AS_n = 1'b1;
      repeat (2) @(negedge CLK);
      RESET_n = 1'b1;
      repeat (3) @(posedge CLK);
      #1;

      // Sequence restarts at board 0; 48 without 4A uses the cleared staging nibble.
      do_read("rst b0 rd00", 24'hE80000, 1'b1, 4'hE);
      do_write("rst b0 wr48", 24'hE80048, 4'h3);
      check("rst b0 BASE", BASE, 16'h0030);
      check("rst b0 CONFIGURED_n", CONFIGURED_n, 2'b10);

      // AS_n pulse without DS_n: nothing happens, board 1 stays current.
      @(negedge CLK);
      A    = 23'(24'hE8004C >> 1);
      RW_n = 1'b0;
      AS_n = 1'b0;
      repeat (4) @(negedge CLK);
      AS_n = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      check("asonly CONFIGURED_n", CONFIGURED_n, 2'b10);
      check("asonly CFGOUT_n", CFGOUT_n, 1'b1);
      do_read("asonly b1 rd00", 24'hE80000, 1'b1, 4'hD);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
